// File: rtl/dec_scan_seq.sv
// dec_scan_seq: registered sequencer driving the enable/select inputs (e, x1, x0)
// of a 2-to-4 decoder. On start it walks the four select codes (ascending or
// descending), holding each for DWELL cycles, for PASSES sweeps, then pulses done.
// Ports: clk, rst_n (async active-low), start, stop, dir -> e, x1, x0, busy, done.
// Optional: define DEC_SCAN_GAP_EN to insert a 1-cycle e=0 gap between codes.
module dec_scan_seq #(
  parameter int DWELL  = 4,
  parameter int PASSES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic stop,
  input  logic dir,
  output logic e,
  output logic x1,
  output logic x0,
  output logic busy,
  output logic done
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int PS_W = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL - 1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PASSES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
`ifdef DEC_SCAN_GAP_EN
    GAP,
`endif
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      code_q, code_d;
  logic            dir_q, dir_d;
  logic [DW_W-1:0] dwell_q, dwell_d;
  logic [PS_W-1:0] pass_q, pass_d;
  logic            e_q, e_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            last_code;

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    dir_d     = dir_q;
    dwell_d   = dwell_q;
    pass_d    = pass_q;
    last_code = dir_q ? (code_q == 2'b00) : (code_q == 2'b11);

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = SCAN;
          dir_d   = dir;
          code_d  = dir ? 2'b11 : 2'b00;
          dwell_d = '0;
          pass_d  = '0;
        end
      end
      SCAN: begin
        if (stop) begin
          state_d = IDLE;
          code_d  = '0;
        end else if (dwell_q == DW_LAST) begin
          if (last_code && (pass_q == PS_LAST)) begin
            state_d = DONE;
          end else begin
            code_d  = dir_q ? (code_q - 2'd1) : (code_q + 2'd1);
            dwell_d = '0;
            if (last_code) begin
              pass_d = pass_q + PS_W'(1);
            end
`ifdef DEC_SCAN_GAP_EN
            state_d = GAP;
`endif
          end
        end else begin
          dwell_d = dwell_q + DW_W'(1);
        end
      end
`ifdef DEC_SCAN_GAP_EN
      GAP: begin
        dwell_d = '0;
        if (stop) begin
          state_d = IDLE;
          code_d  = '0;
        end else begin
          state_d = SCAN;
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
        code_d  = '0;
      end
      default: begin
        state_d = IDLE;
        code_d  = '0;
      end
    endcase

    // Outputs are decoded from the next state so they come straight off flops.
    e_d    = (state_d == SCAN);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= '0;
      dir_q   <= 1'b0;
      dwell_q <= '0;
      pass_q  <= '0;
      e_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      dir_q   <= dir_d;
      dwell_q <= dwell_d;
      pass_q  <= pass_d;
      e_q     <= e_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign e    = e_q;
  assign x1   = code_q[1];
  assign x0   = code_q[0];
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_dec_scan_seq.sv
module tb_dec_scan_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic a_start = 1'b0, a_stop = 1'b0, a_dir = 1'b0;
  logic a_e, a_x1, a_x0, a_busy, a_done;
  logic b_start = 1'b0, b_stop = 1'b0, b_dir = 1'b0;
  logic b_e, b_x1, b_x0, b_busy, b_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dec_scan_seq #(.DWELL(4), .PASSES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .stop(a_stop), .dir(a_dir),
    .e(a_e), .x1(a_x1), .x0(a_x0), .busy(a_busy), .done(a_done)
  );

  dec_scan_seq #(.DWELL(1), .PASSES(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .stop(b_stop), .dir(b_dir),
    .e(b_e), .x1(b_x1), .x0(b_x0), .busy(b_busy), .done(b_done)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  // exp packs {e, x1, x0, busy, done}
  task automatic chk_a(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {a_e, a_x1, a_x0, a_busy, a_done};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed={e,x1,x0,busy,done}=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {b_e, b_x1, b_x0, b_busy, b_done};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed={e,x1,x0,busy,done}=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Full single-pass scan on dut_a; dir is flipped right after acceptance to
  // show it is ignored while busy.
  task automatic run_full_a(input logic d);
    logic [1:0] code;
    logic [1:0] nxt;
    a_dir = d;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    a_dir = ~d;
    code = 2'b00;
    for (int unsigned k = 0; k < 4; k++) begin
      code = d ? 2'(3 - k) : 2'(k);
      for (int unsigned j = 0; j < 4; j++) begin
        chk_a($sformatf("a_dir%0d_code%0d_dw%0d", d, k, j), {1'b1, code, 1'b1, 1'b0});
        tick();
      end
`ifdef DEC_SCAN_GAP_EN
      if (k < 3) begin
        nxt = d ? (code - 2'd1) : (code + 2'd1);
        chk_a($sformatf("a_dir%0d_gap%0d", d, k), {1'b0, nxt, 1'b1, 1'b0});
        tick();
      end
`endif
    end
    chk_a($sformatf("a_dir%0d_done", d), {1'b0, code, 1'b1, 1'b1});
    tick();
    chk_a($sformatf("a_dir%0d_idle", d), 5'b00000);
  endtask

  initial begin
    // Reset state
    #2;
    chk_a("a_reset", 5'b00000);
    chk_b("b_reset", 5'b00000);
    tick();
    rst_n = 1'b1;
    tick();
    chk_a("a_after_reset", 5'b00000);

    // Ascending, then descending full scans
    run_full_a(1'b0);
    tick();
    run_full_a(1'b1);
    tick();

    // DWELL=1, PASSES=3: every code for one cycle, three sweeps
    b_dir = 1'b0;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int unsigned p = 0; p < 3; p++) begin
      for (int unsigned k = 0; k < 4; k++) begin
        chk_b($sformatf("b_p%0d_code%0d", p, k), {1'b1, 2'(k), 1'b1, 1'b0});
        tick();
`ifdef DEC_SCAN_GAP_EN
        if (!(p == 2 && k == 3)) begin
          chk_b($sformatf("b_p%0d_gap%0d", p, k), {1'b0, 2'(k + 1), 1'b1, 1'b0});
          tick();
        end
`endif
      end
    end
    chk_b("b_done", 5'b01111);
    tick();
    chk_b("b_idle", 5'b00000);
    tick();

    // stop in cycle 6 of an ascending scan, restart from 00
    a_dir = 1'b0;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int unsigned c = 1; c < 6; c++) tick();
    chk_a("stop_cyc6_scan", 5'b10110);
    a_stop = 1'b1;
    tick();
    a_stop = 1'b0;
    chk_a("stop_cyc7_idle", 5'b00000);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    chk_a("stop_restart_cyc8", 5'b10010);
    a_stop = 1'b1;
    tick();
    a_stop = 1'b0;
    chk_a("stop_again_idle", 5'b00000);
    tick();
    chk_a("stop_no_done", 5'b00000);

    // Async reset mid-scan with start held high throughout
    a_start = 1'b1;
    tick();
    chk_a("rst_cyc1", 5'b10010);
    for (int unsigned c = 1; c < 10; c++) tick();
    checks++;
    assert (a_busy === 1'b1) else begin
      errors++;
      $error("FAIL rst_cyc10_busy observed=%b expected=1", a_busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk_a("rst_async_clear", 5'b00000);
    tick();
    chk_a("rst_held_start_ignored", 5'b00000);
    a_start = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk_a("rst_release_idle", 5'b00000);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    chk_a("rst_new_scan", 5'b10010);
    a_stop = 1'b1;
    tick();
    a_stop = 1'b0;
    chk_a("rst_new_scan_stopped", 5'b00000);

    // start and stop together in IDLE
    a_start = 1'b1;
    a_stop = 1'b1;
    tick();
    chk_a("start_stop_idle1", 5'b00000);
    tick();
    chk_a("start_stop_idle2", 5'b00000);
    a_start = 1'b0;
    a_stop = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
